// File: rtl/ifu_pc.sv
// ifu_pc: instruction-fetch program counter for a single-issue MIPS-style core.
// It holds the fetch address and picks the next one from jr, jump, branch or
// sequential flow. It checks that address against the legal fetch window. An
// illegal target parks the unit in HALT with the offending address latched.
// Only reset leaves HALT.
module ifu_pc #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] PC_LIMIT = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic [15:0] imm16,
  input  logic        jump,
  input  logic [25:0] instr_index,
  input  logic        jr,
  input  logic [31:0] rs_value,
  output logic [31:0] pc,
  output logic [31:0] pc_4,
  output logic        fetch_valid,
  output logic        halted,
  output logic [31:0] fault_addr,
  output logic [31:0] fetch_count
);

  // Two-state controller: fetching normally, or stopped on a bad target.
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]  state_reg;
  logic [0:0]  state_next;
  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] fault_addr_reg;
  logic [31:0] fault_addr_next;
  logic [31:0] fetch_count_reg;
  logic [31:0] fetch_count_next;

  logic [31:0] pc_4_w;
  logic [31:0] branch_offset;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] target;
  logic        target_aligned;
  logic        target_in_window;
  logic        target_legal;
  logic        advance;

  // Sequential address. It also feeds the link path, and it wraps mod 2^32.
  assign pc_4_w = pc_reg + 32'd4;

  // The branch offset counts words. Sign-extend it, then shift it to bytes.
  assign branch_offset = {{14{imm16[15]}}, imm16, 2'b00};
  assign branch_target = pc_4_w + branch_offset;

  // A j/jal target keeps the region bits of the delay-slot address.
  assign jump_target = {pc_4_w[31:28], instr_index, 2'b00};

  // Target select. Several redirects may be raised in the same cycle.
  // Fixed priority (jr, then jump, then branch) picks one without flagging an error.
  always_comb begin
    target = pc_4_w;
    if (jr) begin
      target = rs_value;
    end else if (jump) begin
      target = jump_target;
    end else if (branch) begin
      target = branch_target;
    end
  end

  // A legal target is word aligned and lies inside [PC_RESET, PC_LIMIT] (unsigned).
  assign target_aligned   = (target[1:0] == 2'b00);
  assign target_in_window = (target >= PC_RESET) && (target <= PC_LIMIT);
  assign target_legal     = target_aligned && target_in_window;

  // The PC only moves when running, not stalled, and the target passes the check.
  assign advance = (state_reg == ST_RUN) && !stall && target_legal;

  // Next-state logic: advance, fault into HALT, or hold everything.
  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    fault_addr_next  = fault_addr_reg;
    fetch_count_next = fetch_count_reg;
    case (state_reg)
      ST_RUN: begin
        if (!stall) begin
          if (target_legal) begin
            pc_next          = target;
            fetch_count_next = fetch_count_reg + 32'd1;
          end else begin
            fault_addr_next  = target;
            state_next       = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        // Frozen. Stall and redirects have no effect; only reset recovers.
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_HALT;
      end
    endcase
  end

  // State registers. Reset takes priority over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_RUN;
      pc_reg          <= PC_RESET;
      fault_addr_reg  <= 32'd0;
      fetch_count_reg <= 32'd0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      fault_addr_reg  <= fault_addr_next;
      fetch_count_reg <= fetch_count_next;
    end
  end

  // Outputs come straight from registers. The status flags decode only the
  // registered state, so no input reaches them combinationally.
  assign pc          = pc_reg;
  assign pc_4        = pc_4_w;
  assign fault_addr  = fault_addr_reg;
  assign fetch_count = fetch_count_reg;
  assign fetch_valid = (state_reg == ST_RUN);
  assign halted      = (state_reg == ST_HALT);

  // Unused signal, kept for debug visibility of the aligned/window split.
  logic unused_advance;
  assign unused_advance = advance;

endmodule

// File: tb/tb_ifu_pc.sv
// Testbench for ifu_pc. It drives directed scenarios followed by a random
// segment. A reference model computes the expected outputs after each edge
// and pushes them into a scoreboard queue. The entry is popped and compared
// once the DUT has updated.
module tb_ifu_pc;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] PC_LIMIT = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch;
  logic [15:0] imm16;
  logic        jump;
  logic [25:0] instr_index;
  logic        jr;
  logic [31:0] rs_value;
  logic [31:0] pc;
  logic [31:0] pc_4;
  logic        fetch_valid;
  logic        halted;
  logic [31:0] fault_addr;
  logic [31:0] fetch_count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_4;
    logic        fv;
    logic        hl;
    logic [31:0] fault;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state.
  logic [31:0] m_pc;
  logic        m_halt;
  logic [31:0] m_fault;
  logic [31:0] m_cnt;

  ifu_pc #(.PC_RESET(PC_RESET), .PC_LIMIT(PC_LIMIT)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .imm16(imm16),
    .jump(jump), .instr_index(instr_index), .jr(jr), .rs_value(rs_value),
    .pc(pc), .pc_4(pc_4), .fetch_valid(fetch_valid), .halted(halted),
    .fault_addr(fault_addr), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    reset = 0; stall = 0; branch = 0; imm16 = 16'h0; jump = 0;
    instr_index = 26'h0; jr = 0; rs_value = 32'h0;
  endtask

  // Update the model from the driven inputs and queue the expected result.
  // Then clock the DUT and compare it against the popped entry.
  task automatic step(input string tag);
    exp_t e;
    logic [31:0] seq, tgt, off;
    seq = m_pc + 32'd4;
    off = {{14{imm16[15]}}, imm16, 2'b00};
    if (jr)          tgt = rs_value;
    else if (jump)   tgt = {seq[31:28], instr_index, 2'b00};
    else if (branch) tgt = seq + off;
    else             tgt = seq;
    if (reset) begin
      m_pc = PC_RESET; m_cnt = 0; m_fault = 0; m_halt = 0;
    end else if (!m_halt && !stall) begin
      if (tgt[1:0] == 2'b00 && tgt >= PC_RESET && tgt <= PC_LIMIT) begin
        m_pc = tgt; m_cnt = m_cnt + 1;
      end else begin
        m_fault = tgt; m_halt = 1;
      end
    end
    e.pc = m_pc; e.pc_4 = m_pc + 32'd4; e.fv = !m_halt; e.hl = m_halt;
    e.fault = m_fault; e.cnt = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".pc"}, pc, e.pc);
    chk({tag, ".pc_4"}, pc_4, e.pc_4);
    chk({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, e.fv});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, e.hl});
    chk({tag, ".fault_addr"}, fault_addr, e.fault);
    chk({tag, ".fetch_count"}, fetch_count, e.cnt);
    $display("step %-10s pc=%h cnt=%0d fv=%b halted=%b fault=%h",
             tag, pc, fetch_count, fetch_valid, halted, fault_addr);
  endtask

  task automatic do_reset();
    idle(); reset = 1; step("reset"); reset = 0;
  endtask

  initial begin
    m_pc = 0; m_halt = 0; m_fault = 0; m_cnt = 0;
    idle();
    reset = 1;
    jr = 1; rs_value = 32'h0000_0001;   // reset must win over a faulting redirect
    step("rst_redir");
    idle();
    chk("rst.pc", pc, 32'h3000);
    chk("rst.pc_4", pc_4, 32'h3004);
    chk("rst.fv", {31'd0, fetch_valid}, 32'd1);
    chk("rst.halted", {31'd0, halted}, 32'd0);
    chk("rst.cnt", fetch_count, 32'd0);
    chk("rst.fault", fault_addr, 32'd0);

    // Free run for three cycles.
    step("run1"); step("run2"); step("run3");
    chk("free.pc", pc, 32'h300C);
    chk("free.cnt", fetch_count, 32'd3);
    chk("free.pc_4", pc_4, 32'h3010);

    // Backward branch by one word from 0x3008.
    do_reset(); step("run1"); step("run2");
    branch = 1; imm16 = 16'hFFFF; step("bbranch"); idle();
    chk("bbranch.pc", pc, 32'h3008);
    chk("bbranch.cnt", fetch_count, 32'd3);
    branch = 1; imm16 = 16'h0010; step("fbranch"); idle();
    chk("fbranch.pc", pc, 32'h304C);

    // All three redirects at once: jr wins.
    do_reset();
    jr = 1; jump = 1; branch = 1; rs_value = 32'h3100; instr_index = 26'h0000C80; imm16 = 16'h0004;
    step("prio"); idle();
    chk("prio.pc", pc, 32'h3100);
    jump = 1; branch = 1; instr_index = 26'h0000C80; imm16 = 16'h0004;
    step("prio_j"); idle();
    chk("prio_j.pc", pc, 32'h3200);

    // A stall holds the PC and swallows the jump.
    do_reset(); step("run1");
    stall = 1; jump = 1; instr_index = 26'h0000D00;
    step("stall1"); step("stall2"); idle();
    chk("stall.pc", pc, 32'h3004);
    chk("stall.cnt", fetch_count, 32'd1);
    step("release");
    chk("release.pc", pc, 32'h3008);

    // Boundary: PC_LIMIT is legal, and so is a jump back to PC_RESET.
    jr = 1; rs_value = PC_LIMIT; step("jr_limit"); idle();
    chk("jr_limit.pc", pc, 32'h6FFC);
    jump = 1; instr_index = 26'h0000C00; step("j_base"); idle();
    chk("j_base.pc", pc, 32'h3000);

    // Misaligned jr target faults; the unit then ignores jump, stall and branch.
    jr = 1; rs_value = 32'h3002; step("fault_mis"); idle();
    chk("fault_mis.halted", {31'd0, halted}, 32'd1);
    chk("fault_mis.fv", {31'd0, fetch_valid}, 32'd0);
    chk("fault_mis.addr", fault_addr, 32'h3002);
    chk("fault_mis.pc", pc, 32'h3000);
    jump = 1; instr_index = 26'h0000C00; step("halt_j"); idle();
    stall = 1; branch = 1; step("halt_sb"); idle();
    chk("halt.pc", pc, 32'h3000);

    // Reset recovers from HALT.
    do_reset();
    chk("rhalt.pc", pc, 32'h3000);
    chk("rhalt.halted", {31'd0, halted}, 32'd0);
    chk("rhalt.fault", fault_addr, 32'd0);

    // A jump above PC_LIMIT faults.
    jump = 1; instr_index = 26'h0001C00; step("fault_hi"); idle();
    chk("fault_hi.addr", fault_addr, 32'h7000);
    chk("fault_hi.halted", {31'd0, halted}, 32'd1);

    // So does a target just below PC_RESET.
    do_reset();
    jr = 1; rs_value = 32'h2FFC; step("fault_lo"); idle();
    chk("fault_lo.addr", fault_addr, 32'h2FFC);

    // Random traffic, checked only through the scoreboard.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      idle();
      reset  = (m_halt && $urandom_range(0, 2) == 0) || ($urandom_range(0, 40) == 0);
      stall  = ($urandom_range(0, 3) == 0);
      jr     = ($urandom_range(0, 7) == 0);
      jump   = ($urandom_range(0, 7) == 0);
      branch = ($urandom_range(0, 3) == 0);
      rs_value = PC_RESET + 32'($urandom_range(0, 32'h4400));
      if ($urandom_range(0, 1) == 0) rs_value[1:0] = 2'b00;
      instr_index = 26'(32'hC00 + $urandom_range(0, 32'h1100));
      imm16 = 16'($urandom);
      if ($urandom_range(0, 1) == 0) imm16 = 16'($signed(6'($urandom)));
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifu_pc.md
IFU_PC -- requirements
Module: ifu_pc

Interface
REQ-001 SHALL provide parameter PC_RESET, default 32'h0000_3000, meaning the PC value loaded on reset and the lowest legal fetch address.
REQ-002 SHALL provide parameter PC_LIMIT, default 32'h0000_6FFC, meaning the highest legal fetch address (inclusive).
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; reset input 1, synchronous active-high reset.
REQ-004 SHALL have port stall input 1: hold PC this cycle.
REQ-005 SHALL have port branch input 1: branch taken.
REQ-006 SHALL have port imm16 input 16: branch offset in words, signed.
REQ-007 SHALL have port jump input 1: j/jal redirect.
REQ-008 SHALL have port instr_index input 26: jump target index.
REQ-009 SHALL have port jr input 1: jr/jalr redirect.
REQ-010 SHALL have port rs_value input 32: jr target.
REQ-011 SHALL have port pc output 32: current fetch address, registered.
REQ-012 SHALL have port pc_4 output 32: pc+4, to the link path.
REQ-013 SHALL have port fetch_valid output 1: pc is a legal fetch this cycle.
REQ-014 SHALL have port halted output 1: the FSM is in HALT.
REQ-015 SHALL have port fault_addr output 32: the rejected target address.
REQ-016 SHALL have port fetch_count output 32: number of PC advances since reset.

Function
REQ-017 SHALL implement a two-state FSM, RUN and HALT; reset enters RUN.
REQ-018 SHALL compute pc_4 = pc + 4 combinationally, modulo 2^32.
REQ-019 SHALL select the next target in priority order:
- jr: rs_value
- jump: {pc_4[31:28], instr_index, 2'b00}
- branch: pc_4 + (sign-extended imm16 << 2), modulo 2^32
- otherwise: pc_4
REQ-020 SHALL resolve simultaneous jr, jump and branch strictly by the REQ-019 priority, with no error.
REQ-021 SHALL, in RUN with stall=0 and a legal target, load the target into pc on the next rising edge and increment fetch_count by 1, wrapping 0xFFFF_FFFF to 0.
REQ-022 SHALL define a legal target as one with target[1:0]==0 and PC_RESET <= target <= PC_LIMIT, compared unsigned.
REQ-023 SHALL, in RUN with stall=0 and an illegal target, on the next edge:
- leave pc unchanged
- capture the target in fault_addr
- enter HALT
- leave fetch_count unchanged
REQ-024 SHALL, when stall=1, hold pc and fetch_count and ignore all redirects; stall is not a fault, and redirects lost to a stall are re-asserted by the upstream stage.
REQ-025 SHALL, in HALT, freeze pc, fault_addr and fetch_count, ignore stall and all redirects, and leave HALT only through reset.
REQ-026 SHALL drive fetch_valid = (state==RUN) and halted = (state==HALT), both decoded from registered state only.
REQ-027 SHALL have latency of one cycle from a redirect input to the new pc; there is no combinational path from inputs to pc, fetch_valid or halted.

Reset
REQ-028 SHALL, on reset=1 at a rising edge, set the following regardless of state, stall or redirects:
- pc = PC_RESET (so pc_4 = PC_RESET+4)
- fetch_count = 0
- fault_addr = 0
- state = RUN (so fetch_valid = 1, halted = 0)
REQ-029 SHALL give reset priority over every other input, including reset asserted mid-redirect and reset asserted in HALT.

Verification
REQ-030 Free run: reset, then 3 idle cycles -> pc 0x3000, 0x3004, 0x3008, 0x300C; fetch_count = 3; pc_4 = 0x3010.
REQ-031 Backward branch: at pc = 0x3008, branch=1, imm16 = 0xFFFF -> pc = 0x3008 next cycle; fetch_count increments.
REQ-032 Priority: at pc = 0x3000, jr=1, jump=1, branch=1, rs_value = 0x3100, instr_index = 0x0000C80 -> pc = 0x3100.
REQ-033 Stall: at pc = 0x3004, stall=1 with jump=1 for 2 cycles -> pc stays 0x3004 and fetch_count is unchanged; with stall released and no redirect -> pc = 0x3008.
REQ-034 Fault:
- jr=1, rs_value = 0x3002 -> halted=1, fetch_valid=0, fault_addr = 0x3002, pc held; jump to 0x3000 has no effect.
- jump with instr_index = 0x0001C00 (target 0x7000, above PC_LIMIT) -> same fault behaviour, fault_addr = 0x7000.
REQ-035 Reset from HALT: reset in HALT -> pc = 0x3000, halted=0, fault_addr=0, fetch_count=0.
